// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and key-address helper for the AES round controller.
package aes_pkg;

    localparam int unsigned AES_NR128 = 10;
    localparam int unsigned AES_DW    = 128;
    localparam int unsigned RK_AW     = 4;
    localparam int unsigned SEL_W     = 2;

    localparam logic [SEL_W-1:0] SEL_FIRST = 2'b00;
    localparam logic [SEL_W-1:0] SEL_MID   = 2'b01;
    localparam logic [SEL_W-1:0] SEL_LAST  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_e;

    // Key address to present during the next round: min(r+2, nr), computed
    // one bit wider so r=14 does not wrap before the clamp.
    function automatic logic [RK_AW-1:0] rk_next(input logic [RK_AW-1:0] r,
                                                 input logic [RK_AW-1:0] nr);
        logic [RK_AW:0] sum;
        sum = {1'b0, r} + (RK_AW+1)'(2);
        if (sum > {1'b0, nr}) begin
            return nr;
        end
        return sum[RK_AW-1:0];
    endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: owns the state register, the stream
// handshakes and round-key RAM addressing, and steps an external
// combinational round core once per clock for NR+1 rounds.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR128,
    parameter int unsigned DW = AES_DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [RK_AW-1:0] rk_addr,
    input  logic [DW-1:0]    rk_data,
    output logic [DW-1:0]    core_din,
    output logic [DW-1:0]    core_kin,
    output logic [SEL_W-1:0] core_sel,
    input  logic [DW-1:0]    core_dout,
    output logic             busy,
    output logic [RK_AW-1:0] round_idx
);

    localparam logic [RK_AW-1:0] NR_IDX = RK_AW'(NR);

    ctrl_state_e      fsm_q;
    ctrl_state_e      fsm_d;
    logic [DW-1:0]    state_q;
    logic [DW-1:0]    state_d;
    logic [DW-1:0]    out_data_d;
    logic             out_valid_d;
    logic [RK_AW-1:0] rk_addr_d;
    logic [RK_AW-1:0] round_idx_d;

    // Handshake and status decode; reset blocks acceptance in the same cycle.
    assign in_ready = (fsm_q == ST_IDLE) && !rst;
    assign busy     = (fsm_q != ST_IDLE);
    assign core_din = state_q;
    assign core_kin = rk_data;

    // Round-type select for the core; only meaningful during ROUND.
    always_comb begin
        core_sel = SEL_FIRST;
        if (fsm_q == ST_ROUND) begin
            if (round_idx == '0) begin
                core_sel = SEL_FIRST;
            end else if (round_idx == NR_IDX) begin
                core_sel = SEL_LAST;
            end else begin
                core_sel = SEL_MID;
            end
        end
    end

    // Next-state and next-register computation.
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        rk_addr_d   = rk_addr;
        round_idx_d = round_idx;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        unique case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d     = in_data;
                    rk_addr_d   = '0;
                    round_idx_d = '0;
                    fsm_d       = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Key 0 is on its way out of the RAM; start prefetching key 1.
                rk_addr_d = RK_AW'(1);
                fsm_d     = ST_ROUND;
            end
            ST_ROUND: begin
                state_d   = core_dout;
                rk_addr_d = rk_next(round_idx, NR_IDX);
                if (round_idx == NR_IDX) begin
                    out_data_d  = core_dout;
                    out_valid_d = 1'b1;
                    fsm_d       = ST_DONE;
                end else begin
                    round_idx_d = round_idx + RK_AW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // Register update with synchronous reset; a reset abandons any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= ST_IDLE;
            state_q   <= '0;
            rk_addr   <= '0;
            round_idx <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            fsm_q     <= fsm_d;
            state_q   <= state_d;
            rk_addr   <= rk_addr_d;
            round_idx <= round_idx_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: an NR=10 and an NR=14 instance, each with an XOR
// stub core and a key RAM holding key[r] = {16{8'h0r}}.
module tb_aes_round_ctrl;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [1:0]             in_valid;
    logic [1:0]             in_ready;
    logic [1:0][127:0]      in_data;
    logic [1:0]             out_valid;
    logic [1:0]             out_ready;
    logic [1:0][127:0]      out_data;
    logic [1:0][3:0]        rk_addr;
    logic [1:0][127:0]      rk_data;
    logic [1:0][127:0]      core_din;
    logic [1:0][127:0]      core_kin;
    logic [1:0][1:0]        core_sel;
    logic [1:0][127:0]      core_dout;
    logic [1:0]             busy;
    logic [1:0][3:0]        round_idx;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(10), .DW(128)) dut10 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .rk_addr(rk_addr[0]), .rk_data(rk_data[0]),
        .core_din(core_din[0]), .core_kin(core_kin[0]), .core_sel(core_sel[0]),
        .core_dout(core_dout[0]), .busy(busy[0]), .round_idx(round_idx[0])
    );

    aes_round_ctrl #(.NR(14), .DW(128)) dut14 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .rk_addr(rk_addr[1]), .rk_data(rk_data[1]),
        .core_din(core_din[1]), .core_kin(core_kin[1]), .core_sel(core_sel[1]),
        .core_dout(core_dout[1]), .busy(busy[1]), .round_idx(round_idx[1])
    );

    // Stub round core and synchronous key RAM.
    assign core_dout[0] = core_din[0] ^ core_kin[0];
    assign core_dout[1] = core_din[1] ^ core_kin[1];
    always @(posedge clk) begin
        rk_data[0] <= {16{4'h0, rk_addr[0]}};
        rk_data[1] <= {16{4'h0, rk_addr[1]}};
    end

    function automatic int nr_of(input int i);
        return (i == 0) ? 10 : 14;
    endfunction

    function automatic logic [127:0] key_of(input int r);
        logic [7:0] b;
        b = 8'(r);
        return {16{b}};
    endfunction

    // XOR of keys 0..n-1: what an XOR core accumulates after n rounds.
    function automatic logic [127:0] xor_keys(input int n);
        logic [127:0] x;
        x = '0;
        for (int j = 0; j < n; j++) x = x ^ key_of(j);
        return x;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    // Transaction-level model: per instance, busy flag, edges since accept, block.
    bit           m_busy [2] = '{0, 0};
    int           m_k    [2] = '{0, 0};
    logic [127:0] m_blk  [2];
    bit           started = 0;

    always @(posedge clk) begin
        started <= 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_busy[i] = 0;
                m_k[i]    = 0;
            end else if (!m_busy[i]) begin
                if (in_valid[i]) begin
                    m_busy[i] = 1;
                    m_k[i]    = 0;
                    m_blk[i]  = in_data[i];
                end
            end else if (m_k[i] >= nr_of(i) + 2 && out_ready[i]) begin
                m_busy[i] = 0;
            end else if (m_k[i] < nr_of(i) + 2) begin
                m_k[i] = m_k[i] + 1;
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                automatic int nr = nr_of(i);
                automatic int k  = m_k[i];
                automatic int r  = k - 1;
                automatic bit in_round = m_busy[i] && k >= 1 && k <= nr + 1;
                automatic bit done     = m_busy[i] && k >= nr + 2;
                automatic int exp_sel  = !in_round ? 0 : (r == 0) ? 0 : (r == nr) ? 2 : 1;
                chk($sformatf("d%0d_in_ready", i), 128'(in_ready[i]), 128'(!m_busy[i] && !rst));
                chk($sformatf("d%0d_busy", i), 128'(busy[i]), 128'(m_busy[i]));
                chk($sformatf("d%0d_out_valid", i), 128'(out_valid[i]), 128'(done));
                chk($sformatf("d%0d_core_sel", i), 128'(core_sel[i]), 128'(exp_sel));
                if (m_busy[i] && k == 0) begin
                    chk($sformatf("d%0d_fetch_din", i), core_din[i], m_blk[i]);
                    chk($sformatf("d%0d_fetch_rk", i), 128'(rk_addr[i]), 128'(0));
                    chk($sformatf("d%0d_fetch_ridx", i), 128'(round_idx[i]), 128'(0));
                end else if (in_round) begin
                    chk($sformatf("d%0d_r%0d_din", i, r), core_din[i], m_blk[i] ^ xor_keys(r));
                    chk($sformatf("d%0d_r%0d_kin", i, r), core_kin[i], key_of(r));
                    chk($sformatf("d%0d_r%0d_ridx", i, r), 128'(round_idx[i]), 128'(r));
                    chk($sformatf("d%0d_r%0d_rk", i, r), 128'(rk_addr[i]), 128'((r + 1 > nr) ? nr : r + 1));
                end else if (done) begin
                    chk($sformatf("d%0d_done_data", i), out_data[i], m_blk[i] ^ xor_keys(nr + 1));
                    chk($sformatf("d%0d_done_rk", i), 128'(rk_addr[i]), 128'(nr));
                end
            end
        end
    end

    // Accept / output-handshake monitor for instance 0, and rk_addr ceiling for instance 1.
    int           cyc = 0;
    int           acc_q[$];
    logic [127:0] oq[$];
    int           rk_max14 = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid[0] && in_ready[0]) acc_q.push_back(cyc);
        if (!rst && out_valid[0] && out_ready[0]) oq.push_back(out_data[0]);
    end
    always @(negedge clk) begin
        if (started && int'(rk_addr[1]) > rk_max14) rk_max14 <= int'(rk_addr[1]);
    end

    logic [1:0] sel_tr [32];
    logic [3:0] rk_tr  [32];
    logic [3:0] ridx_tr[32];

    task automatic wait_ready(input int i);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready[i] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk($sformatf("d%0d_ready_timeout", i), 128'(0), 128'(1));
    endtask

    // Accept one block, measure edges until out_valid, check result, hand it off.
    task automatic run_block(input int i, input logic [127:0] d, input int exp_lat,
                             input logic [127:0] exp_out, input string nm);
        int cnt;
        wait_ready(i);
        #1;
        in_data[i]  = d;
        in_valid[i] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
        cnt = 0;
        while (!out_valid[i] && cnt < 40) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (i == 0 && cnt < 32) begin
                sel_tr[cnt]  = core_sel[0];
                rk_tr[cnt]   = rk_addr[0];
                ridx_tr[cnt] = round_idx[0];
            end
        end
        chk({nm, "_latency"}, 128'(cnt), 128'(exp_lat));
        chk({nm, "_data"}, out_data[i], exp_out);
        #1;
        out_ready[i] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[i] = 1'b0;
        @(negedge clk);
        chk({nm, "_valid_drop"}, 128'(out_valid[i]), 128'(0));
    endtask

    initial begin
        logic [127:0] a_blk, b_blk, lit;
        logic [127:0] b2b_lit[4];
        int n;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d_rst_out_valid", i), 128'(out_valid[i]), 128'(0));
            chk($sformatf("d%0d_rst_out_data", i), out_data[i], 128'(0));
            chk($sformatf("d%0d_rst_rk", i), 128'(rk_addr[i]), 128'(0));
            chk($sformatf("d%0d_rst_ridx", i), 128'(round_idx[i]), 128'(0));
            chk($sformatf("d%0d_rst_busy", i), 128'(busy[i]), 128'(0));
            chk($sformatf("d%0d_rst_in_ready", i), 128'(in_ready[i]), 128'(0));
        end
        rst = 1'b0;

        // Single block plus round sequencing trace.
        run_block(0, 128'h0, 12, {16{8'h0B}}, "t1");
        chk("t2_sel_r0", 128'(sel_tr[1]), 128'(2'b00));
        chk("t2_sel_r1", 128'(sel_tr[2]), 128'(2'b01));
        chk("t2_sel_r9", 128'(sel_tr[10]), 128'(2'b01));
        chk("t2_sel_r10", 128'(sel_tr[11]), 128'(2'b10));
        chk("t2_rk_r0", 128'(rk_tr[1]), 128'(1));
        chk("t2_rk_r9", 128'(rk_tr[10]), 128'(10));
        chk("t2_rk_r10", 128'(rk_tr[11]), 128'(10));
        chk("t2_ridx_r4", 128'(ridx_tr[5]), 128'(4));
        chk("t2_ridx_r10", 128'(ridx_tr[11]), 128'(10));

        // Backpressure: result held, second block waits.
        a_blk = 128'h00112233445566778899aabbccddeeff;
        b_blk = {16{8'hA5}};
        wait_ready(0);
        #1;
        in_data[0]  = a_blk;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_data[0] = b_blk;
        n = 0;
        while (!out_valid[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        lit = 128'h0b1a29384f5e6d7c8392a1b0c7d6e5f4;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("t3_hold_valid", 128'(out_valid[0]), 128'(1));
            chk("t3_hold_data", out_data[0], lit);
            chk("t3_hold_in_ready", 128'(in_ready[0]), 128'(0));
        end
        #1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        @(negedge clk);
        chk("t3_idle_in_ready", 128'(in_ready[0]), 128'(1));
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t3_second_data", out_data[0], {16{8'hAE}});
        #1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back blocks with out_ready held high.
        acc_q.delete();
        oq.delete();
        b2b_lit = '{{16{8'h1A}}, {16{8'h29}}, {16{8'h38}}, {16{8'h4F}}};
        for (int b = 1; b <= 4; b++) begin
            wait_ready(0);
            #1;
            in_data[0]  = {16{8'(b * 17)}};
            in_valid[0] = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid[0] = 1'b0;
        repeat (20) @(posedge clk);
        chk("t4_accepts", 128'(acc_q.size()), 128'(4));
        chk("t4_outputs", 128'(oq.size()), 128'(4));
        if (acc_q.size() == 4 && oq.size() == 4) begin
            for (int j = 0; j < 4; j++) chk($sformatf("t4_out%0d", j), oq[j], b2b_lit[j]);
            for (int j = 1; j < 4; j++) chk($sformatf("t4_gap%0d", j), 128'(acc_q[j] - acc_q[j-1]), 128'(14));
        end

        // Reset in round 5, then a fresh block.
        wait_ready(0);
        #1;
        in_data[0]  = {16{8'h77}};
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(busy[0] && round_idx[0] == 4'd5) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_r5", 128'(round_idx[0]), 128'(5));
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_out_valid", 128'(out_valid[0]), 128'(0));
        chk("t5_out_data", out_data[0], 128'(0));
        chk("t5_busy", 128'(busy[0]), 128'(0));
        chk("t5_ridx", 128'(round_idx[0]), 128'(0));
        chk("t5_rk", 128'(rk_addr[0]), 128'(0));
        chk("t5_in_ready", 128'(in_ready[0]), 128'(1));
        out_ready[0] = 1'b0;
        run_block(0, {16{8'h3C}}, 12, {16{8'h37}}, "t5_after");

        // NR=14 instance.
        run_block(1, 128'h0, 16, {16{8'h0F}}, "t6");
        chk("t6_rk_max", 128'(rk_max14 <= 14), 128'(1));
        chk("t6_rk_reached", 128'(rk_max14), 128'(14));

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
